// File: rtl/sram_like_axi_bridge.sv
// Bridges the core's SRAM-like fetch and data ports onto one single-beat AXI3 master.
// One read in flight (shared by both ports) plus at most one data write alongside it.
module sram_like_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_DONE} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B, W_DONE} wstate_t;

  rstate_t     r_state, r_next;
  wstate_t     w_state, w_next;
  logic        r_own_data;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] w_addr, w_data;
  logic [1:0]  w_size;
  logic [3:0]  w_strb, strb_in;
  logic        aw_done, w_done;
  logic        rd_take_data, rd_take_inst, wr_take;
  logic        rd_done, w_ok;

  // Data reads wait for an idle write side so a read never overtakes a pending write.
  assign rd_take_data = ~rst & (r_state == R_IDLE) & data_req & ~data_wr & (w_state == W_IDLE);
  assign rd_take_inst = ~rst & (r_state == R_IDLE) & inst_req & ~rd_take_data;
  assign wr_take      = ~rst & (w_state == W_IDLE) & data_req & data_wr;

  assign inst_addr_ok = rd_take_inst;
  assign data_addr_ok = rd_take_data | wr_take;

  // A write accepted behind an in-flight data read holds its completion one cycle
  // rather than collide with that read's data_ok.
  assign rd_done      = (r_state == R_DONE);
  assign w_ok         = (w_state == W_DONE) & ~(rd_done & r_own_data);
  assign inst_data_ok = rd_done & ~r_own_data;
  assign data_data_ok = (rd_done & r_own_data) | w_ok;

  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_R);
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};

  assign awvalid = (w_state == W_REQ) & ~aw_done;
  assign wvalid  = (w_state == W_REQ) & ~w_done;
  assign bready  = (w_state == W_B);
  assign awaddr  = w_addr;
  assign awsize  = {1'b0, w_size};
  assign wdata   = w_data;
  assign wstrb   = w_strb;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (rd_take_data | rd_take_inst) r_next = R_AR;
      R_AR:   if (arready) r_next = R_R;
      R_R:    if (rvalid) r_next = R_DONE;
      R_DONE: r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_own_data <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      r_state <= r_next;
      if (rd_take_data) begin
        r_own_data <= 1'b1;
        r_addr     <= data_addr;
        r_size     <= data_size;
      end else if (rd_take_inst) begin
        r_own_data <= 1'b0;
        r_addr     <= inst_addr;
        r_size     <= 2'd2;
      end
      if (r_state == R_R && rvalid) begin
        if (r_own_data) data_rdata <= rdata;
        else            inst_rdata <= rdata;
      end
    end
  end

  always_comb begin
    strb_in = 4'b1111;
    case (data_size)
      2'd0:    strb_in = 4'b0001 << data_addr[1:0];
      2'd1:    strb_in = data_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_in = 4'b1111;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (wr_take) w_next = W_REQ;
      W_REQ:  if ((aw_done | awready) & (w_done | wready)) w_next = W_B;
      W_B:    if (bvalid) w_next = W_DONE;
      W_DONE: if (w_ok) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_size  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (wr_take) begin
        w_addr <= data_addr;
        w_size <= data_size;
        w_data <= data_wdata;
        w_strb <= strb_in;
      end
      if (w_state == W_REQ) begin
        if (awready) aw_done <= 1'b1;
        if (wready)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

endmodule
